// File: rtl/aes_pkg.sv
// aes_pkg: FIPS-197 forward and inverse S-box tables plus the byte-lane width.
package aes_pkg;
  localparam int BYTE_W = 8;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
endpackage

// File: rtl/sbox_dual.sv
// sbox_dual: combinational single-byte forward/inverse S-box lookup.
module sbox_dual
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] value,
  input  logic              inv,
  output logic [BYTE_W-1:0] result
);
  assign result = inv ? INV_SBOX[value] : SBOX[value];
endmodule

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: per-lane AES SubBytes/InvSubBytes with a valid/ready register pipeline.
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES       = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_inv,
  input  logic [BYTE_W*LANES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_inv,
  output logic [BYTE_W*LANES-1:0] out_data,
  output logic                    busy
);
  localparam int W = BYTE_W * LANES;
  // Entry 0 of each chain is the looked-up input; entry s+1 is stage s.
  logic [PIPE_STAGES:0] chain_v, chain_m;
  logic [W-1:0]         chain_d [PIPE_STAGES+1];
  logic [PIPE_STAGES-1:0] load;
  logic                   nxt;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_dual u_sbox (
      .value  (in_data[BYTE_W*l +: BYTE_W]),
      .inv    (in_inv),
      .result (chain_d[0][BYTE_W*l +: BYTE_W])
    );
  end
  assign chain_v[0] = in_valid;
  assign chain_m[0] = in_inv;
  // A stage can take new content when it is empty or the stage after it is taking its content.
  always_comb begin
    nxt  = out_ready;
    load = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      load[k] = !chain_v[k+1] || nxt;
      nxt     = load[k];
    end
  end
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic         v;
    logic         m;
    logic [W-1:0] d;
    always_ff @(posedge clk) begin
      if (!rst_n || flush) v <= 1'b0;
      else if (load[s]) v <= chain_v[s];
      if (load[s]) begin
        d <= chain_d[s];
        m <= chain_m[s];
      end
    end
    assign chain_v[s+1] = v;
    assign chain_m[s+1] = m;
    assign chain_d[s+1] = d;
  end
  assign in_ready  = rst_n && !flush && load[0];
  assign out_valid = chain_v[PIPE_STAGES];
  assign out_inv   = chain_m[PIPE_STAGES];
  assign out_data  = chain_d[PIPE_STAGES];
  assign busy      = |chain_v[PIPE_STAGES:1];
endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb_sub_bytes_pipe: random and directed checks of sub_bytes_pipe against a GF(2^8) S-box model.
module tb_sub_bytes_pipe;
  localparam int LANES  = 16;
  localparam int STAGES = 2;
  localparam int W      = 8 * LANES;
  logic clk = 1'b0;
  logic rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_inv, busy;
  logic [W-1:0] out_data;
  sub_bytes_pipe #(.LANES(LANES), .PIPE_STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_inv(out_inv), .out_data(out_data), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];
  logic [W-1:0] exp_d [$];
  logic         exp_m [$];
  logic [W-1:0] log_d [$];
  logic         log_m [$];
  logic saw_out, saw_ready, saw_busy;
  logic [W-1:0] saw_data;
  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = m ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction
  task automatic build_tables();
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask
  // One clock cycle: sample mid-cycle, update the scoreboard, then move past the next edge.
  task automatic tick();
    @(negedge clk);
    saw_out = out_valid;
    saw_ready = in_ready;
    saw_busy = busy;
    saw_data = out_data;
    if (in_valid && in_ready) begin
      exp_d.push_back(model(in_data, in_inv));
      exp_m.push_back(in_inv);
    end
    if (out_valid && out_ready) begin
      log_d.push_back(out_data);
      log_m.push_back(out_inv);
      if (exp_d.size() == 0) check("spurious_out", W'(out_valid), W'(0));
      else begin
        check("sb_data", out_data, exp_d.pop_front());
        check("sb_inv", W'(out_inv), W'(exp_m.pop_front()));
      end
    end
    if (flush || !rst_n) begin
      exp_d.delete();
      exp_m.delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d, input logic m);
    in_valid = 1'b1;
    in_data = d;
    in_inv = m;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (saw_ready) break;
    end
    in_valid = 1'b0;
    check("send_ready", W'(saw_ready), W'(1));
  endtask
  task automatic wait_out(input string tag);
    int lat;
    for (lat = 1; lat <= 10; lat++) begin
      tick();
      if (saw_out) break;
    end
    check(tag, W'(lat), W'(STAGES));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] d, e, x, y;
    logic [7:0] a3 [3], b3 [3];
    int cyc, sent, n0;
    build_tables();
    repeat (2) tick();
    check("rst_out_valid", W'(saw_out), W'(0));
    check("rst_busy", W'(saw_busy), W'(0));
    check("rst_in_ready", W'(saw_ready), W'(0));
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", W'(saw_ready), W'(1));
    check("rel_out_valid", W'(saw_out), W'(0));
    send('0, 1'b0);
    wait_out("lat_fwd00");
    check("fwd_00", log_d[$], {LANES{8'h63}});
    for (int i = 0; i < LANES; i++) begin
      d[8*i +: 8] = i[0] ? 8'hff : 8'h53;
      e[8*i +: 8] = i[0] ? 8'h16 : 8'hed;
    end
    send(d, 1'b0);
    wait_out("lat_fwd53");
    check("fwd_53ff", log_d[$], e);
    a3 = '{8'h63, 8'hed, 8'h16};
    b3 = '{8'h00, 8'h53, 8'hff};
    for (int i = 0; i < LANES; i++) begin
      d[8*i +: 8] = a3[i % 3];
      e[8*i +: 8] = b3[i % 3];
    end
    send(d, 1'b1);
    wait_out("lat_inv");
    check("inv_known", log_d[$], e);
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b0);
    wait_out("lat_rt_fwd");
    y = log_d[$];
    send(y, 1'b1);
    wait_out("lat_rt_inv");
    check("roundtrip", log_d[$], x);
    log_d.delete();
    log_m.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = '0;
      in_inv = i[0];
      tick();
    end
    in_valid = 1'b0;
    repeat (STAGES + 2) tick();
    check("alt_count", W'(log_d.size()), W'(4));
    for (int i = 0; i < 4 && i < log_d.size(); i++) begin
      check("alt_data", log_d[i], {LANES{i[0] ? 8'h52 : 8'h63}});
      check("alt_inv", W'(log_m[i]), W'(i[0]));
    end
    log_d.delete();
    log_m.delete();
    cyc = 0;
    sent = 0;
    while (log_d.size() < 20 && cyc < 100) begin
      in_valid = sent < 20;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_inv = 1'($urandom_range(0, 1));
      tick();
      if (in_valid && saw_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("thru_count", W'(log_d.size()), W'(20));
    check("thru_cycles", W'(cyc), W'(20 + STAGES));
    log_d.delete();
    log_m.delete();
    cyc = 0;
    sent = 0;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_inv = 1'($urandom_range(0, 1));
    while ((sent < 100 || log_d.size() < 100) && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = sent < 100;
      tick();
      if (in_valid && saw_ready) begin
        sent++;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_inv = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", W'(log_d.size()), W'(100));
    check("stream_pending", W'(exp_d.size()), W'(0));
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (STAGES + 2) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_inv = 1'($urandom_range(0, 1));
      tick();
    end
    check("full_in_ready", W'(saw_ready), W'(0));
    in_valid = 1'b0;
    repeat (2) begin
      tick();
      check("hold_valid", W'(saw_out), W'(1));
      check("hold_data", saw_data, exp_d.size() > 0 ? exp_d[0] : ~saw_data);
    end
    n0 = log_d.size();
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    check("flush_in_ready", W'(saw_ready), W'(0));
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("flush_out_valid", W'(saw_out), W'(0));
    check("flush_busy", W'(saw_busy), W'(0));
    repeat (4) tick();
    check("flush_no_output", W'(log_d.size()), W'(n0));
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_in_ready", W'(saw_ready), W'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_out_valid", W'(saw_out), W'(0));
    check("post_rst_busy", W'(saw_busy), W'(0));
    check("post_rst_in_ready", W'(saw_ready), W'(1));
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b1);
    wait_out("lat_post_rst");
    check("post_rst_data", log_d[$], model(x, 1'b1));
    repeat (4) tick();
    check("final_pending", W'(exp_d.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sub_bytes_pipe.md
SUB_BYTES_PIPE -- requirements
Module: sub_bytes_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16, giving the number of byte lanes (1..32).
REQ-002 SHALL have parameter PIPE_STAGES, default 2, giving the pipeline depth (1..3).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all in-flight beats.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_inv  input  1  per-beat mode: 0 = forward S-box, 1 = inverse S-box.
REQ-009 in_data  input  8*LANES  input bytes; lane i = bits [8i+7:8i].
REQ-010 out_valid  output  1  output beat present.
REQ-011 out_ready  input  1  downstream accepts the beat.
REQ-012 out_inv  output  1  mode bit that travelled with the beat.
REQ-013 out_data  output  8*LANES  substituted bytes, lane-aligned with in_data.
REQ-014 busy  output  1  high when any pipeline stage holds a valid beat.

Function
REQ-015 SHALL compute out lane i = SBOX(in lane i) when in_inv=0, and INV_SBOX(in lane i) when in_inv=1, per FIPS-197, independently for each lane.
REQ-016 SHALL accept a beat on a cycle where in_valid && in_ready; SHALL transfer a beat out on a cycle where out_valid && out_ready.
REQ-017 SHALL implement PIPE_STAGES registered stages, each with a valid bit, data and mode; lookup occurs combinationally before stage 0 register.
REQ-018 Stage k SHALL load from stage k-1 (stage 0 from input) when stage k is empty or stage k's content advances in the same cycle.
REQ-019 in_ready SHALL equal !stage0_valid || stage0 advances this cycle (full-throughput, one beat per cycle with no bubbles when out_ready=1).
REQ-020 With out_ready held high, a beat accepted at cycle N SHALL appear with out_valid=1 at cycle N+PIPE_STAGES.
REQ-021 With out_ready low, stage contents SHALL hold unchanged; out_data/out_inv SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 No beat SHALL be dropped, duplicated or reordered under any out_ready pattern.
REQ-023 in_inv SHALL be sampled with its beat; mixed forward/inverse beats back-to-back SHALL each use their own mode.
REQ-024 flush=1 SHALL clear every stage valid bit at the next edge; in_ready SHALL be 0 during flush, so no beat is accepted in a flush cycle, even with in_valid=1.
REQ-025 out_valid SHALL equal the last stage valid bit; busy SHALL equal OR of all stage valid bits.
REQ-026 Data registers need not be reset; only valid bits are reset.

Reset
REQ-027 On a clk edge with rst_n=0, all stage valid bits SHALL clear; out_valid=0, busy=0, in_ready=0 while rst_n=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight beats; first cycle after rst_n=1 SHALL have in_ready=1, out_valid=0.
REQ-029 out_data and out_inv SHALL be don't-care while out_valid=0.

Structure
REQ-030 Shared package aes_pkg SHALL hold the 256-entry SBOX and INV_SBOX constant tables and the byte-lane width constant.
REQ-031 One sub-module, sbox_dual (8-bit in, inv select, 8-bit out, combinational), SHALL be instantiated LANES times.
REQ-032 Pipeline stages SHALL use a generate loop over PIPE_STAGES; no other sub-modules.

Verification
REQ-033 LANES=16, in_inv=0, in_data all 0x00 -> out_data all 0x63 after 2 cycles; lanes 0x53/0xFF -> 0xED/0x16.
REQ-034 in_inv=1, lanes 0x63/0xED/0x16 -> 0x00/0x53/0xFF; round-trip forward then inverse of random 128-bit value returns original.
REQ-035 Stream 100 back-to-back beats, out_ready random 50% -> all 100 outputs in order, correct, none lost; with out_ready=1 throughput exactly 1/cycle.
REQ-036 Alternate in_inv 0,1,0,1 on consecutive beats of 0x00 -> outputs 0x63, 0x52, 0x63, 0x52 with out_inv matching.
REQ-037 Fill pipe with out_ready=0, assert flush one cycle with in_valid=1 -> next cycle out_valid=0, busy=0, flushed-cycle input not accepted.
REQ-038 rst_n=0 for one cycle with 2 beats in flight -> out_valid=0, busy=0 after edge; new beat after release emerges with correct latency.
